layer_sequencer: RTL and testbench

- Top-level scheduler for the fixed-point DNN inference pipeline. It runs NUM_LAYERS layer engines (FC1, FC2, ...) strictly one after another.
- For each layer it drives the layer's ena and synchronous-reset input, waits for the layer's done, and collects sticky overflow.
- Grants the single shared MultAdder and the weight-ROM address port to the active layer only, through an explicit mux. The design never relies on tri-stated buses.

---
 rtl/layer_sequencer.sv | 140 ++++++++++++++
 tb/tb_layer_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Sequences the DNN layer engines one after another and grants the shared
// MultAdder and weight-ROM address port to the active layer only.
module layer_sequencer #(
  parameter int NUM_LAYERS = 2,
  parameter int BIT_W      = 16,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 4095
) (
  input  logic                          clk,
  input  logic                          iRst_n,
  input  logic                          iStart,
  input  logic [NUM_LAYERS-1:0]         iLayerDone,
  input  logic [NUM_LAYERS-1:0]         iLayerOvf,
  input  logic [NUM_LAYERS*11-1:0]      iLayerAddr,
  input  logic [NUM_LAYERS*128*BIT_W-1:0] iLayerOpr1,
  input  logic [NUM_LAYERS*128*BIT_W-1:0] iLayerOpr2,
  output logic [NUM_LAYERS-1:0]         oLayerEna,
  output logic                          oLayerRst_n,
  output logic [10:0]                   addr_to_rom,
  output logic [128*BIT_W-1:0]          opr1_to_MultAdder,
  output logic [128*BIT_W-1:0]          opr2_to_MultAdder,
  output logic [3:0]                    oLayerIdx,
  output logic                          oBusy,
  output logic                          oDone,
  output logic                          oOverflow,
  output logic                          oTimeout
);

  localparam int OPR_W = 128 * BIT_W;
  localparam logic [11:0] WD_LAST   = 12'(TIMEOUT - 1);
  localparam logic [7:0]  RCNT_LAST = 8'(RST_CYCLES - 1);
  localparam logic [3:0]  IDX_LAST  = 4'(NUM_LAYERS - 1);

  typedef enum logic [2:0] {
    IDLE, LRST, RUN, NEXT, FINISH, ERR
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic [11:0] wd_q, wd_d;
  logic        ovf_q, ovf_d;
  logic        grant;

  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rcnt_q  <= '0;
      wd_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rcnt_q  <= rcnt_d;
      wd_q    <= wd_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rcnt_d  = rcnt_q;
    wd_d    = wd_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, FINISH: begin
        if (iStart) begin
          state_d = LRST;
          idx_d   = '0;
          rcnt_d  = '0;
          wd_d    = '0;
          ovf_d   = 1'b0;
        end
      end
      LRST: begin
        rcnt_d = rcnt_q + 8'd1;
        if (rcnt_q == RCNT_LAST) begin
          state_d = RUN;
          rcnt_d  = '0;
          wd_d    = '0;
        end
      end
      RUN: begin
        wd_d = wd_q + 12'd1;
        // Completion wins over an expiring watchdog in the same cycle.
        if (iLayerDone[idx_q]) begin
          ovf_d   = ovf_q | iLayerOvf[idx_q];
          state_d = NEXT;
        end else if (wd_q == WD_LAST) begin
          state_d = ERR;
        end
      end
      NEXT: begin
        wd_d = '0;
        if (idx_q == IDX_LAST) begin
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + 4'd1;
          rcnt_d  = '0;
          state_d = LRST;
        end
      end
      ERR: state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  assign grant = (state_q == LRST) || (state_q == RUN);

  always_comb begin
    oLayerEna = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (grant && (idx_q == 4'(k))) oLayerEna[k] = 1'b1;
    end
  end

  // Shared-resource mux: an explicit AND-OR select, zero when nothing is granted.
  always_comb begin
    addr_to_rom       = '0;
    opr1_to_MultAdder = '0;
    opr2_to_MultAdder = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (grant && (idx_q == 4'(k))) begin
        addr_to_rom       = iLayerAddr[k*11 +: 11];
        opr1_to_MultAdder = iLayerOpr1[k*OPR_W +: OPR_W];
        opr2_to_MultAdder = iLayerOpr2[k*OPR_W +: OPR_W];
      end
    end
  end

  assign oLayerRst_n = (state_q != LRST);
  assign oLayerIdx   = idx_q;
  assign oBusy       = (state_q == LRST) || (state_q == RUN) || (state_q == NEXT);
  assign oDone       = (state_q == FINISH);
  assign oOverflow   = ovf_q;
  assign oTimeout    = (state_q == ERR);

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with two layers and a shortened watchdog.
module tb_layer_sequencer;

  localparam int NL    = 2;
  localparam int BW    = 16;
  localparam int OW    = 128 * BW;
  localparam int TO    = 40;

  logic              clk = 1'b0;
  logic              iRst_n;
  logic              iStart;
  logic [NL-1:0]     iLayerDone;
  logic [NL-1:0]     iLayerOvf;
  logic [NL*11-1:0]  iLayerAddr;
  logic [NL*OW-1:0]  iLayerOpr1;
  logic [NL*OW-1:0]  iLayerOpr2;
  logic [NL-1:0]     oLayerEna;
  logic              oLayerRst_n;
  logic [10:0]       addr_to_rom;
  logic [OW-1:0]     opr1_to_MultAdder;
  logic [OW-1:0]     opr2_to_MultAdder;
  logic [3:0]        oLayerIdx;
  logic              oBusy, oDone, oOverflow, oTimeout;

  int checks = 0;
  int failures = 0;

  localparam logic [63:0] P1_0 = 64'h0123_4567_89ab_cdef;
  localparam logic [63:0] P1_1 = 64'hfedc_ba98_7654_3210;
  localparam logic [63:0] P2_0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] P2_1 = 64'h5555_6666_7777_8888;

  layer_sequencer #(.NUM_LAYERS(NL), .BIT_W(BW), .RST_CYCLES(2), .TIMEOUT(TO)) dut (
    .clk(clk), .iRst_n(iRst_n), .iStart(iStart),
    .iLayerDone(iLayerDone), .iLayerOvf(iLayerOvf), .iLayerAddr(iLayerAddr),
    .iLayerOpr1(iLayerOpr1), .iLayerOpr2(iLayerOpr2),
    .oLayerEna(oLayerEna), .oLayerRst_n(oLayerRst_n), .addr_to_rom(addr_to_rom),
    .opr1_to_MultAdder(opr1_to_MultAdder), .opr2_to_MultAdder(opr2_to_MultAdder),
    .oLayerIdx(oLayerIdx), .oBusy(oBusy), .oDone(oDone),
    .oOverflow(oOverflow), .oTimeout(oTimeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic chk_idle_mux(input string tag);
    chk({tag, "_ena"}, 64'(oLayerEna), 64'd0);
    chk({tag, "_addr"}, 64'(addr_to_rom), 64'd0);
    chk({tag, "_opr1"}, opr1_to_MultAdder[63:0], 64'd0);
    chk({tag, "_opr2"}, opr2_to_MultAdder[OW-1 -: 64], 64'd0);
  endtask

  // Entered in the first LRST cycle; leaves in the NEXT cycle after done.
  task automatic run_layer(input int k, input int n, input bit ovf);
    logic [1:0]  oh;
    logic [10:0] ea;
    logic [63:0] e1, e2;
    oh = 2'b01 << k;
    ea = (k == 0) ? 11'h001 : 11'h40b;
    e1 = (k == 0) ? P1_0 : P1_1;
    e2 = (k == 0) ? P2_0 : P2_1;
    chk("lrst1_ena", 64'(oLayerEna), 64'(oh));
    chk("lrst1_rstn", 64'(oLayerRst_n), 64'd0);
    chk("lrst1_idx", 64'(oLayerIdx), 64'(k));
    chk("lrst1_busy", 64'(oBusy), 64'd1);
    chk("lrst_addr", 64'(addr_to_rom), 64'(ea));
    tick();
    chk("lrst2_rstn", 64'(oLayerRst_n), 64'd0);
    chk("lrst2_ena", 64'(oLayerEna), 64'(oh));
    tick();
    chk("run1_rstn", 64'(oLayerRst_n), 64'd1);
    chk("run1_ena", 64'(oLayerEna), 64'(oh));
    chk("run_addr", 64'(addr_to_rom), 64'(ea));
    chk("run_opr1_lo", opr1_to_MultAdder[63:0], e1);
    chk("run_opr1_hi", opr1_to_MultAdder[OW-1 -: 64], e1);
    chk("run_opr2_lo", opr2_to_MultAdder[63:0], e2);
    if (n >= 2) begin
      // Foreign done and a stray start must both be ignored.
      iLayerDone = ~oh;
      iStart = 1'b1;
      tick();
      iLayerDone = '0;
      iStart = 1'b0;
      chk("run2_ena", 64'(oLayerEna), 64'(oh));
      chk("run2_idx", 64'(oLayerIdx), 64'(k));
      chk("run2_rstn", 64'(oLayerRst_n), 64'd1);
      for (int i = 2; i < n; i++) tick();
    end
    chk("run_last_ena", 64'(oLayerEna), 64'(oh));
    chk("run_last_to", 64'(oTimeout), 64'd0);
    iLayerDone[k] = 1'b1;
    iLayerOvf[k] = ovf;
    tick();
    iLayerDone = '0;
    iLayerOvf = '0;
    chk_idle_mux("next");
    chk("next_busy", 64'(oBusy), 64'd1);
    chk("next_to", 64'(oTimeout), 64'd0);
  endtask

  initial begin
    iRst_n = 1'b0;
    iStart = 1'b0;
    iLayerDone = '0;
    iLayerOvf = '0;
    iLayerAddr = {11'h40b, 11'h001};
    iLayerOpr1 = {{32{P1_1}}, {32{P1_0}}};
    iLayerOpr2 = {{32{P2_1}}, {32{P2_0}}};
    #2;
    chk("rst_rstn", 64'(oLayerRst_n), 64'd1);
    chk("rst_busy", 64'(oBusy), 64'd0);
    chk("rst_done", 64'(oDone), 64'd0);
    chk("rst_idx", 64'(oLayerIdx), 64'd0);
    chk_idle_mux("rst");
    tick();
    iRst_n = 1'b1;
    tick();
    chk_idle_mux("idle");

    // Normal run: done at RUN cycle 30 then 12, no overflow.
    do_start();
    run_layer(0, 30, 1'b0);
    tick();
    run_layer(1, 12, 1'b0);
    tick();
    chk("fin1_done", 64'(oDone), 64'd1);
    chk("fin1_busy", 64'(oBusy), 64'd0);
    chk("fin1_ovf", 64'(oOverflow), 64'd0);
    chk_idle_mux("fin1");

    // Overflow from layer 0 sticks through layer 1.
    do_start();
    chk("st2_done", 64'(oDone), 64'd0);
    run_layer(0, 5, 1'b1);
    chk("ovf_after_l0", 64'(oOverflow), 64'd1);
    tick();
    run_layer(1, 1, 1'b0);
    tick();
    chk("fin2_done", 64'(oDone), 64'd1);
    chk("fin2_ovf", 64'(oOverflow), 64'd1);

    // Restart clears flags; done coincides with watchdog expiry.
    do_start();
    chk("st3_done", 64'(oDone), 64'd0);
    chk("st3_ovf", 64'(oOverflow), 64'd0);
    run_layer(0, TO, 1'b0);
    tick();
    run_layer(1, 3, 1'b0);
    tick();
    chk("fin3_done", 64'(oDone), 64'd1);
    chk("fin3_to", 64'(oTimeout), 64'd0);

    // Watchdog: layer 0 never finishes.
    do_start();
    tick();
    tick();
    for (int i = 1; i < TO; i++) tick();
    chk("wd_last_ena", 64'(oLayerEna), 64'd1);
    chk("wd_last_to", 64'(oTimeout), 64'd0);
    tick();
    chk("err_to", 64'(oTimeout), 64'd1);
    chk("err_busy", 64'(oBusy), 64'd0);
    chk("err_done", 64'(oDone), 64'd0);
    chk_idle_mux("err");
    do_start();
    tick();
    chk("err_start_to", 64'(oTimeout), 64'd1);
    chk("err_start_ena", 64'(oLayerEna), 64'd0);
    #2;
    iRst_n = 1'b0;
    #1;
    chk("err_rst_to", 64'(oTimeout), 64'd0);
    #2;
    iRst_n = 1'b1;
    tick();
    chk("post_err_busy", 64'(oBusy), 64'd0);
    chk("post_err_to", 64'(oTimeout), 64'd0);

    // Async reset in the middle of layer 1 RUN.
    do_start();
    run_layer(0, 4, 1'b1);
    tick();
    tick();
    tick();
    tick();
    chk("mid_ena", 64'(oLayerEna), 64'd2);
    chk("mid_ovf", 64'(oOverflow), 64'd1);
    #2;
    iRst_n = 1'b0;
    #1;
    chk("arst_rstn", 64'(oLayerRst_n), 64'd1);
    chk("arst_idx", 64'(oLayerIdx), 64'd0);
    chk("arst_busy", 64'(oBusy), 64'd0);
    chk("arst_ovf", 64'(oOverflow), 64'd0);
    chk("arst_done", 64'(oDone), 64'd0);
    chk_idle_mux("arst");
    #2;
    iRst_n = 1'b1;
    tick();
    do_start();
    chk("restart_ena", 64'(oLayerEna), 64'd1);
    chk("restart_idx", 64'(oLayerIdx), 64'd0);
    chk("restart_busy", 64'(oBusy), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
